// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one synchronous-FIFO write port between N_REQ
// producers. Round-robin ownership with bounded bursts. Every word is confirmed
// through the FIFO's registered wr_ack/overflow response and is retried until it
// is accepted, so no producer word is lost or duplicated.
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]            grant,
  output logic [N_REQ-1:0]            done,
  output logic                        busy,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_data_in,
  input  logic                        fifo_full,
  input  logic                        fifo_wr_ack,
  input  logic                        fifo_overflow
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [CNT_W-1:0] burst_cnt;
  logic             locked;
  logic             retry;

  logic [PTR_W-1:0] winner;
  logic             any_req;

  // Pointer increment with an explicit wrap, so N_REQ need not be a power of 2.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return PTR_W'(sum);
  endfunction

  function automatic logic [N_REQ-1:0] to_onehot(input logic [PTR_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Round-robin pick: first set req at or after rr_ptr. Scanning from the far
  // end down lets the nearest requester overwrite the farther ones.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise
    // paths that skip the assignment would infer a latch.
    winner  = '0;
    any_req = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[wrap_add(rr_ptr, k)]) begin
        winner  = wrap_add(rr_ptr, k);
        any_req = 1'b1;
      end
    end
  end

  // done is a same-cycle echo of the FIFO acknowledge for the current owner.
  assign done = (state == CHECK && fifo_wr_ack) ? grant : '0;
  assign busy = (state != IDLE) || locked;

  // Arbitration FSM: IDLE picks/keeps an owner and latches its word, WRITE
  // pulses the FIFO enable, CHECK consumes the registered FIFO response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state        <= IDLE;
      grant        <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      rr_ptr       <= '0;
      owner        <= '0;
      burst_cnt    <= '0;
      locked       <= 1'b0;
      retry        <= 1'b0;
    end else begin
      fifo_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (retry) begin
            // Re-send the rejected word already held in fifo_data_in.
            if (!fifo_full) begin
              state      <= WRITE;
              fifo_wr_en <= 1'b1;
            end
          end else if (locked) begin
            if (!req[owner]) begin
              grant     <= '0;
              locked    <= 1'b0;
              burst_cnt <= '0;
              rr_ptr    <= wrap_add(owner, 1);
            end else if (!fifo_full) begin
              fifo_data_in <= wdata[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
              state        <= WRITE;
              fifo_wr_en   <= 1'b1;
            end
          end else if (any_req) begin
            // Ownership is taken even while the FIFO is full; the owner then
            // waits in the locked path until there is room.
            owner     <= winner;
            grant     <= to_onehot(winner);
            locked    <= 1'b1;
            burst_cnt <= '0;
            if (!fifo_full) begin
              fifo_data_in <= wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
              state        <= WRITE;
              fifo_wr_en   <= 1'b1;
            end
          end
        end

        WRITE: state <= CHECK;

        CHECK: begin
          state <= IDLE;
          if (fifo_wr_ack) begin
            // Ack wins even if overflow is also asserted.
            retry <= 1'b0;
            if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
              grant     <= '0;
              locked    <= 1'b0;
              burst_cnt <= '0;
              rr_ptr    <= wrap_add(owner, 1);
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
              locked    <= 1'b1;
            end
          end else if (fifo_overflow) begin
            retry <= 1'b1;
          end else begin
            // No response at all is treated like a rejection.
            retry <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench for fifo_wr_arbiter. Instance a uses
// MAX_BURST=4, instance b uses MAX_BURST=2 for the rotation sequence. A small
// FIFO responder per instance answers each write one cycle later with ack, or
// with overflow when forced.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_a, grant_a, done_a;
  logic [N*DW-1:0] wdata_a;
  logic            busy_a, wr_en_a, full_a, ack_a, ovf_a, ovf_force_a;
  logic [DW-1:0]   data_a;

  logic [N-1:0]    req_b, grant_b, done_b;
  logic [N*DW-1:0] wdata_b;
  logic            busy_b, wr_en_b, full_b, ack_b, ovf_b;
  logic [DW-1:0]   data_b;

  int checks   = 0;
  int failures = 0;
  int exp_own [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) u_a (
    .clk(clk), .rst(rst), .req(req_a), .wdata(wdata_a), .grant(grant_a),
    .done(done_a), .busy(busy_a), .fifo_wr_en(wr_en_a), .fifo_data_in(data_a),
    .fifo_full(full_a), .fifo_wr_ack(ack_a), .fifo_overflow(ovf_a)
  );

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(2)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .wdata(wdata_b), .grant(grant_b),
    .done(done_b), .busy(busy_b), .fifo_wr_en(wr_en_b), .fifo_data_in(data_b),
    .fifo_full(full_b), .fifo_wr_ack(ack_b), .fifo_overflow(ovf_b)
  );

  // FIFO write-side responders: registered answer one cycle after wr_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_a <= 1'b0;
      ovf_a <= 1'b0;
      ack_b <= 1'b0;
      ovf_b <= 1'b0;
    end else begin
      ack_a <= wr_en_a & ~ovf_force_a;
      ovf_a <= wr_en_a & ovf_force_a;
      ack_b <= wr_en_b;
      ovf_b <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word_a(input int i, input logic [DW-1:0] v);
    wdata_a[i*DW +: DW] = v;
  endtask

  task automatic set_word_b(input int i, input logic [DW-1:0] v);
    wdata_b[i*DW +: DW] = v;
  endtask

  // Running invariants: no back-to-back write enables, grant one-hot or zero.
  logic prev_wr_a = 1'b0;
  logic prev_wr_b = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      check("wr_en_b2b_a", 32'(prev_wr_a & wr_en_a), 32'd0);
      check("wr_en_b2b_b", 32'(prev_wr_b & wr_en_b), 32'd0);
      check("grant_onehot_a", 32'($onehot0(grant_a)), 32'd1);
      check("grant_onehot_b", 32'($onehot0(grant_b)), 32'd1);
    end
    prev_wr_a <= wr_en_a;
    prev_wr_b <= wr_en_b;
  end

  initial begin
    int n;
    req_a = '0; wdata_a = '0; full_a = 1'b0; ovf_force_a = 1'b0;
    req_b = '0; wdata_b = '0; full_b = 1'b0;
    #1 rst = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_grant", 32'(grant_a), 32'd0);
    check("rst_wr_en", 32'(wr_en_a), 32'd0);
    check("rst_data", 32'(data_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    rst = 1'b0;
    tick();

    // Single owner burst of 3 words: wr_en at 1,4,7, done at 2,5,8
    set_word_a(0, 16'h0011);
    req_a = 4'b0001;
    tick();                                            // cycle 1
    check("b_c1_wr_en", 32'(wr_en_a), 32'd1);
    check("b_c1_data", 32'(data_a), 32'h11);
    check("b_c1_grant", 32'(grant_a), 32'b0001);
    tick();                                            // cycle 2
    check("b_c2_done", 32'(done_a), 32'b0001);
    check("b_c2_wr_en", 32'(wr_en_a), 32'd0);
    set_word_a(0, 16'h0022);
    tick();                                            // cycle 3
    check("b_c3_wr_en", 32'(wr_en_a), 32'd0);
    check("b_c3_grant", 32'(grant_a), 32'b0001);
    tick();                                            // cycle 4
    check("b_c4_wr_en", 32'(wr_en_a), 32'd1);
    check("b_c4_data", 32'(data_a), 32'h22);
    tick();                                            // cycle 5
    check("b_c5_done", 32'(done_a), 32'b0001);
    set_word_a(0, 16'h0033);
    tick();                                            // cycle 6
    tick();                                            // cycle 7
    check("b_c7_wr_en", 32'(wr_en_a), 32'd1);
    check("b_c7_data", 32'(data_a), 32'h33);
    check("b_c7_grant", 32'(grant_a), 32'b0001);
    tick();                                            // cycle 8
    check("b_c8_done", 32'(done_a), 32'b0001);
    req_a = 4'b0000;
    tick();                                            // cycle 9
    check("b_c9_grant_held", 32'(grant_a), 32'b0001);
    check("b_c9_busy", 32'(busy_a), 32'd1);
    tick();                                            // cycle 10
    check("b_c10_released", 32'(grant_a), 32'd0);
    check("b_c10_busy", 32'(busy_a), 32'd0);

    // rr_ptr=1 now: req0 and req2 together -> owner 2, then owner 0
    set_word_a(0, 16'h00A0);
    set_word_a(2, 16'h00A2);
    req_a = 4'b0101;
    tick();
    check("rr_grant2", 32'(grant_a), 32'b0100);
    check("rr_data2", 32'(data_a), 32'hA2);
    tick();
    check("rr_done2", 32'(done_a), 32'b0100);
    req_a = 4'b0001;
    tick();
    tick();
    check("rr_gap", 32'(grant_a), 32'd0);
    tick();
    check("rr_grant0", 32'(grant_a), 32'b0001);
    check("rr_data0", 32'(data_a), 32'hA0);
    check("rr_wr_en0", 32'(wr_en_a), 32'd1);
    tick();
    check("rr_done0", 32'(done_a), 32'b0001);
    req_a = 4'b0000;
    tick();
    tick();
    check("rr_released", 32'(grant_a), 32'd0);

    // FIFO full when req1 rises: grant given, no write until full drops
    full_a = 1'b1;
    set_word_a(1, 16'h0055);
    req_a = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("full_grant%0d", i), 32'(grant_a), 32'b0010);
      check($sformatf("full_wr_en%0d", i), 32'(wr_en_a), 32'd0);
    end
    full_a = 1'b0;                                     // cycle t
    check("full_drop_t", 32'(wr_en_a), 32'd0);
    tick();                                            // t+1
    check("full_drop_t1", 32'(wr_en_a), 32'd1);
    check("full_drop_data", 32'(data_a), 32'h55);
    tick();                                            // t+2
    check("full_done", 32'(done_a), 32'b0010);

    // Overflow on 0xBEEF: no done, grant held, re-issued once full clears
    set_word_a(1, 16'hBEEF);
    ovf_force_a = 1'b1;
    tick();                                            // t+3
    check("ovf_idle_wr_en", 32'(wr_en_a), 32'd0);
    tick();                                            // t+4
    check("ovf_wr_en", 32'(wr_en_a), 32'd1);
    check("ovf_data", 32'(data_a), 32'hBEEF);
    tick();                                            // t+5
    check("ovf_seen", 32'(ovf_a), 32'd1);
    check("ovf_no_done", 32'(done_a), 32'd0);
    full_a = 1'b1;
    ovf_force_a = 1'b0;
    tick();                                            // t+6
    check("ovf_hold_grant", 32'(grant_a), 32'b0010);
    check("ovf_hold_wr_en", 32'(wr_en_a), 32'd0);
    tick();                                            // t+7
    check("ovf_stall_wr_en", 32'(wr_en_a), 32'd0);
    full_a = 1'b0;
    tick();                                            // t+8
    check("retry_wr_en", 32'(wr_en_a), 32'd1);
    check("retry_data", 32'(data_a), 32'hBEEF);
    tick();                                            // t+9
    check("retry_done", 32'(done_a), 32'b0010);
    req_a = 4'b0000;
    tick();                                            // t+10
    check("retry_single_done", 32'(done_a), 32'd0);

    // Async reset during WRITE aborts the word; rr_ptr restarts at 0
    set_word_a(2, 16'h0077);
    req_a = 4'b0100;
    n = 0;
    while (!wr_en_a && n < 8) begin
      tick();
      n++;
    end
    check("rstw_reached_write", 32'(wr_en_a), 32'd1);
    check("rstw_owner2", 32'(grant_a), 32'b0100);
    #2 rst = 1'b1;
    #1;
    check("rstw_wr_en", 32'(wr_en_a), 32'd0);
    check("rstw_grant", 32'(grant_a), 32'd0);
    check("rstw_done", 32'(done_a), 32'd0);
    set_word_a(0, 16'h0099);
    req_a = 4'b0101;
    tick();
    rst = 1'b0;
    check("rstw_still_no_done", 32'(done_a), 32'd0);
    tick();
    check("rstw_grant0", 32'(grant_a), 32'b0001);
    check("rstw_data0", 32'(data_a), 32'h99);
    tick();
    check("rstw_done0", 32'(done_a), 32'b0001);
    req_a = 4'b0000;
    tick();
    tick();

    // All four requesting, MAX_BURST=2: owners 0,0,1,1,2,2,3,3,0
    for (int i = 0; i < N; i++) set_word_b(i, DW'(16'h0100 + i));
    req_b = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      n = 0;
      tick();
      while (done_b == '0 && n < 10) begin
        tick();
        n++;
      end
      check($sformatf("rot_done%0d", k), 32'(done_b), 32'd1 << exp_own[k]);
      check($sformatf("rot_data%0d", k), 32'(data_b), 32'h100 + 32'(exp_own[k]));
    end
    req_b = 4'b0000;
    tick();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
